// File: rtl/cpu24_multicycle_sequencer_if.sv
// ---------------------------------------------------------------------------
// cpu24_multicycle_sequencer_if
// Bundles the sequencer's datapath-facing signals.
//   master : the sequencer. It receives Start, opcode, Function, Zero and
//            MemReady, and drives the control strobes, status and InstrCount.
//   slave  : the datapath/memory side, which sees the opposite directions.
// CNT_W must match the CNT_W of the sequencer that is attached.
// ---------------------------------------------------------------------------
interface cpu24_multicycle_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             Start;
    logic [3:0]       opcode;
    logic [3:0]       Function;
    logic             Zero;
    logic             MemReady;
    logic             PCWrite;
    logic             PCSrc;
    logic             IRWrite;
    logic             RegDst;
    logic             ALUSrc;
    logic [1:0]       ALUOp;
    logic             MemRead;
    logic             MemWrite;
    logic             MemToReg;
    logic             RegWrite;
    logic             MulWrite;
    logic             Busy;
    logic             Halted;
    logic             IllegalOp;
    logic             BusError;
    logic [CNT_W-1:0] InstrCount;

    modport master (
        input  Start, opcode, Function, Zero, MemReady,
        output PCWrite, PCSrc, IRWrite, RegDst, ALUSrc, ALUOp,
               MemRead, MemWrite, MemToReg, RegWrite, MulWrite,
               Busy, Halted, IllegalOp, BusError, InstrCount
    );

    modport slave (
        output Start, opcode, Function, Zero, MemReady,
        input  PCWrite, PCSrc, IRWrite, RegDst, ALUSrc, ALUOp,
               MemRead, MemWrite, MemToReg, RegWrite, MulWrite,
               Busy, Halted, IllegalOp, BusError, InstrCount
    );
endinterface

// File: rtl/cpu24_multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// cpu24_multicycle_sequencer
// Multi-cycle control FSM for the 24-bit CPU datapath:
// IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, plus HALT.
// Ports:
//   Clock  : system clock, rising edge
//   ResetN : synchronous active-low reset
//   bus    : master side of cpu24_multicycle_sequencer_if
//            (instruction fields, Zero and MemReady in; strobes, mux
//            selects, status flags and the retired-instruction count out)
// The control outputs are decoded from the state and the opcode/Function
// latched in DECODE. The one exception is the branch PC write in EXEC,
// which also qualifies on the ALU Zero flag.
// ---------------------------------------------------------------------------
module cpu24_multicycle_sequencer #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                          Clock,
    input  logic                          ResetN,
    cpu24_multicycle_sequencer_if.master  bus
);
    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_ANDI  = 4'b0010;
    localparam logic [3:0] OP_ORI   = 4'b0011;
    localparam logic [3:0] OP_LW    = 4'b0100;
    localparam logic [3:0] OP_SW    = 4'b0101;
    localparam logic [3:0] OP_BEQ   = 4'b0110;
    localparam logic [3:0] OP_BNE   = 4'b0111;
    localparam logic [3:0] OP_HALT  = 4'b1111;
    localparam logic [3:0] FN_MUL   = 4'b1000;

    logic [2:0]       state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [3:0]       fn_q, fn_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;

    // Decode of the latched instruction
    logic       is_rtype, is_lw, is_sw, is_branch, branch_taken, alu_src;
    logic [1:0] alu_op;

    always_comb begin
        is_rtype     = (op_q == OP_RTYPE);
        is_lw        = (op_q == OP_LW);
        is_sw        = (op_q == OP_SW);
        is_branch    = (op_q == OP_BEQ) || (op_q == OP_BNE);
        branch_taken = ((op_q == OP_BEQ) && bus.Zero) ||
                       ((op_q == OP_BNE) && !bus.Zero);
        alu_src      = (op_q == OP_ADDI) || (op_q == OP_ANDI) ||
                       (op_q == OP_ORI)  || is_lw || is_sw;
        if (is_rtype)
            alu_op = 2'b10;
        else if ((op_q == OP_ANDI) || (op_q == OP_ORI))
            alu_op = 2'b11;
        else if (is_branch)
            alu_op = 2'b01;
        else
            alu_op = 2'b00;
    end

    // Next-state logic. A retire is any transition into FETCH from
    // EXEC, MEM or WB.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        fn_d        = fn_q;
        to_cnt_d    = to_cnt_q;
        instr_cnt_d = instr_cnt_q;
        illegal_d   = illegal_q;
        bus_err_d   = bus_err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Start)
                    state_d = S_FETCH;
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                op_d = bus.opcode;
                fn_d = bus.Function;
                if (bus.opcode == OP_HALT) begin
                    state_d = S_HALT;
                end else if (bus.opcode[3]) begin
                    // 1000..1110 are undefined
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_branch) begin
                    state_d     = S_FETCH;
                    instr_cnt_d = instr_cnt_q + 1'b1;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (bus.MemReady) begin
                    to_cnt_d = '0;
                    if (is_lw) begin
                        state_d = S_WB;
                    end else begin
                        state_d     = S_FETCH;
                        instr_cnt_d = instr_cnt_q + 1'b1;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    // This was the last allowed MEM cycle without a reply
                    to_cnt_d  = '0;
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_WB: begin
                state_d     = S_FETCH;
                instr_cnt_d = instr_cnt_q + 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            fn_q        <= '0;
            to_cnt_q    <= '0;
            instr_cnt_q <= '0;
            illegal_q   <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            fn_q        <= fn_d;
            to_cnt_q    <= to_cnt_d;
            instr_cnt_q <= instr_cnt_d;
            illegal_q   <= illegal_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Output decode
    logic       pc_write, pc_src, ir_write, reg_dst, alu_src_o;
    logic       mem_read, mem_write, mem_to_reg, reg_write, mul_write;
    logic [1:0] alu_op_o;

    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        alu_src_o  = 1'b0;
        alu_op_o   = 2'b00;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        mul_write  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
            end
            S_EXEC: begin
                alu_src_o = alu_src;
                alu_op_o  = alu_op;
                if (branch_taken) begin
                    pc_write = 1'b1;
                    pc_src   = 1'b1;
                end
            end
            S_MEM: begin
                alu_src_o = alu_src;
                alu_op_o  = alu_op;
                mem_read  = is_lw;
                mem_write = is_sw;
            end
            S_WB: begin
                alu_src_o  = alu_src;
                alu_op_o   = alu_op;
                reg_write  = 1'b1;
                reg_dst    = is_rtype;
                mem_to_reg = is_lw;
                mul_write  = is_rtype && (fn_q == FN_MUL);
            end
            default: ;
        endcase
    end

    assign bus.PCWrite    = pc_write;
    assign bus.PCSrc      = pc_src;
    assign bus.IRWrite    = ir_write;
    assign bus.RegDst     = reg_dst;
    assign bus.ALUSrc     = alu_src_o;
    assign bus.ALUOp      = alu_op_o;
    assign bus.MemRead    = mem_read;
    assign bus.MemWrite   = mem_write;
    assign bus.MemToReg   = mem_to_reg;
    assign bus.RegWrite   = reg_write;
    assign bus.MulWrite   = mul_write;
    assign bus.Busy       = (state_q != S_IDLE) && (state_q != S_HALT);
    assign bus.Halted     = (state_q == S_HALT);
    assign bus.IllegalOp  = illegal_q;
    assign bus.BusError   = bus_err_q;
    assign bus.InstrCount = instr_cnt_q;
endmodule

// File: tb/tb_cpu24_multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu24_multicycle_sequencer
// Instruction-level reference model: each issued instruction expands into
// the per-cycle control vectors it must produce. These vectors go into a
// queue, and a monitor pops and compares one of them every cycle.
// ---------------------------------------------------------------------------
module tb_cpu24_multicycle_sequencer;
    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 15;

    logic Clock  = 1'b0;
    logic ResetN = 1'b0;
    always #5 Clock = ~Clock;

    cpu24_multicycle_sequencer_if #(.CNT_W(CNT_W)) bus ();

    cpu24_multicycle_sequencer #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .Clock  (Clock),
        .ResetN (ResetN),
        .bus    (bus)
    );

    typedef struct packed {
        logic             pcw, pcs, irw, rdst, asrc;
        logic [1:0]       aop;
        logic             mr, mw, m2r, rw, mulw, busy, halt, ill, berr;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    typedef struct {
        vec_t  v;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Architectural model state
    logic [CNT_W-1:0] m_count;
    logic             m_illegal;
    logic             m_buserr;

    function automatic vec_t base(input logic busy);
        vec_t v;
        v      = '0;
        v.busy = busy;
        v.ill  = m_illegal;
        v.berr = m_buserr;
        v.cnt  = m_count;
        return v;
    endfunction

    function automatic vec_t sample();
        vec_t a;
        a.pcw  = bus.PCWrite;   a.pcs  = bus.PCSrc;    a.irw  = bus.IRWrite;
        a.rdst = bus.RegDst;    a.asrc = bus.ALUSrc;   a.aop  = bus.ALUOp;
        a.mr   = bus.MemRead;   a.mw   = bus.MemWrite; a.m2r  = bus.MemToReg;
        a.rw   = bus.RegWrite;  a.mulw = bus.MulWrite; a.busy = bus.Busy;
        a.halt = bus.Halted;    a.ill  = bus.IllegalOp; a.berr = bus.BusError;
        a.cnt  = bus.InstrCount;
        return a;
    endfunction

    // ALU source/operation per instruction class, as an opcode table
    task automatic op_info(input logic [3:0] op, output logic asrc, output logic [1:0] aop);
        case (op)
            4'h0:       begin asrc = 1'b0; aop = 2'b10; end
            4'h1:       begin asrc = 1'b1; aop = 2'b00; end
            4'h2, 4'h3: begin asrc = 1'b1; aop = 2'b11; end
            4'h4, 4'h5: begin asrc = 1'b1; aop = 2'b00; end
            default:    begin asrc = 1'b0; aop = 2'b01; end
        endcase
    endtask

    // Monitor: one comparison per pushed cycle vector
    initial begin : monitor
        exp_t e;
        vec_t a;
        forever begin
            @(negedge Clock);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = sample();
                checks++;
                if (a !== e.v) begin
                    failures++;
                    $display("FAIL %s got=%h want=%h (t=%0t)", e.tag, a, e.v, $time);
                end
            end
        end
    end

    task automatic cyc(input vec_t v, input string tag);
        exp_t e;
        e.v   = v;
        e.tag = tag;
        exp_q.push_back(e);
        @(posedge Clock);
        #1;
    endtask

    task automatic model_clear();
        m_count   = '0;
        m_illegal = 1'b0;
        m_buserr  = 1'b0;
    endtask

    task automatic retire();
        m_count = m_count + 1'b1;
    endtask

    task automatic do_reset();
        ResetN       = 1'b0;
        bus.Start    = 1'b0;
        bus.MemReady = 1'($urandom);
        @(posedge Clock);
        #1;
        ResetN = 1'b1;
        model_clear();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus.Start    = 1'b0;
            bus.opcode   = 4'($urandom);
            bus.Function = 4'($urandom);
            bus.Zero     = 1'($urandom);
            bus.MemReady = 1'($urandom);
            cyc(base(1'b0), "IDLE");
        end
    endtask

    task automatic start_cpu();
        bus.Start = 1'b1;
        cyc(base(1'b0), "IDLE_START");
        bus.Start = 1'b0;
    endtask

    // Start is held high to show that HALT ignores it
    task automatic halt_cycles(input int n);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            bus.Start    = 1'b1;
            bus.MemReady = 1'($urandom);
            v      = base(1'b0);
            v.halt = 1'b1;
            cyc(v, "HALT");
        end
        bus.Start = 1'b0;
    endtask

    // Issue one instruction, starting in the FETCH cycle. wait_n is the
    // number of MEM cycles with MemReady low (negative: never ready);
    // abort resets the DUT during the first MEM cycle.
    task automatic do_instr(input logic [3:0] op, input logic [3:0] fn,
                            input logic zero, input int wait_n, input logic abort);
        vec_t       v;
        logic       asrc;
        logic [1:0] aop;
        logic       done;
        logic       taken;
        done = 1'b0;
        // FETCH: instruction fields are not yet valid
        bus.Start    = 1'($urandom);
        bus.opcode   = 4'($urandom);
        bus.Function = 4'($urandom);
        bus.Zero     = 1'($urandom);
        bus.MemReady = 1'($urandom);
        v = base(1'b1); v.pcw = 1'b1; v.irw = 1'b1;
        cyc(v, "FETCH");
        // DECODE
        bus.opcode   = op;
        bus.Function = fn;
        bus.Start    = 1'($urandom);
        bus.MemReady = 1'($urandom);
        cyc(base(1'b1), "DECODE");
        bus.opcode   = 4'($urandom);
        bus.Function = 4'($urandom);
        $display("instr op=%h fn=%h zero=%0d wait=%0d abort=%0d count_before=%0d",
                 op, fn, zero, wait_n, abort, m_count);
        if (op == 4'hF)
            return;
        if (op > 4'h7) begin
            m_illegal = 1'b1;
            return;
        end
        op_info(op, asrc, aop);
        // EXEC
        bus.Zero     = zero;
        bus.MemReady = 1'($urandom);
        taken = ((op == 4'h6) && zero) || ((op == 4'h7) && !zero);
        v = base(1'b1); v.asrc = asrc; v.aop = aop;
        if (taken) begin v.pcw = 1'b1; v.pcs = 1'b1; end
        cyc(v, "EXEC");
        if ((op == 4'h6) || (op == 4'h7)) begin
            retire();
            return;
        end
        if ((op == 4'h4) || (op == 4'h5)) begin
            for (int i = 0; (i < MEM_TIMEOUT) && !done; i++) begin
                bus.Zero     = 1'($urandom);
                bus.MemReady = (wait_n >= 0) && (i == wait_n);
                v = base(1'b1); v.asrc = asrc; v.aop = aop;
                v.mr = (op == 4'h4);
                v.mw = (op == 4'h5);
                if (abort) ResetN = 1'b0;
                cyc(v, "MEM");
                if (abort) begin
                    ResetN = 1'b1;
                    model_clear();
                    return;
                end
                if (bus.MemReady) done = 1'b1;
            end
            bus.MemReady = 1'b0;
            if (!done) begin
                m_buserr = 1'b1;
                return;
            end
            if (op == 4'h5) begin
                retire();
                return;
            end
        end
        // WB
        bus.MemReady = 1'($urandom);
        v = base(1'b1); v.asrc = asrc; v.aop = aop; v.rw = 1'b1;
        v.rdst = (op == 4'h0);
        v.m2r  = (op == 4'h4);
        v.mulw = (op == 4'h0) && (fn == 4'h8);
        cyc(v, "WB");
        retire();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [3:0] op;
        logic [3:0] fn;
        bus.Start = 1'b0; bus.opcode = '0; bus.Function = '0;
        bus.Zero = 1'b0; bus.MemReady = 1'b0;
        model_clear();
        repeat (2) @(posedge Clock);
        #1;
        do_reset();
        idle_cycles(3);

        // Basic R-type, then directed classes
        start_cpu();
        do_instr(4'h0, 4'h2, 1'b0, 0, 1'b0);
        do_instr(4'h4, 4'h0, 1'b0, 3, 1'b0);   // LW, three wait cycles
        do_instr(4'h6, 4'h0, 1'b1, 0, 1'b0);   // BEQ taken
        do_instr(4'h6, 4'h0, 1'b0, 0, 1'b0);   // BEQ not taken
        do_instr(4'h7, 4'h0, 1'b1, 0, 1'b0);   // BNE not taken
        do_instr(4'h7, 4'h0, 1'b0, 0, 1'b0);   // BNE taken
        do_instr(4'h0, 4'h8, 1'b0, 0, 1'b0);   // MUL
        do_instr(4'h1, 4'h3, 1'b0, 0, 1'b0);
        do_instr(4'h2, 4'h8, 1'b0, 0, 1'b0);   // Function=1000 outside R-type
        do_instr(4'h3, 4'h1, 1'b1, 0, 1'b0);
        do_instr(4'h5, 4'h0, 1'b0, 0, 1'b0);
        do_instr(4'h5, 4'h0, 1'b0, 14, 1'b0);  // ready on the last allowed cycle

        // Randomized legal instructions (counter wraps several times)
        repeat (60) begin
            op = 4'($urandom_range(0, 7));
            fn = ($urandom_range(0, 3) == 0) ? 4'h8 : 4'($urandom);
            do_instr(op, fn, 1'($urandom), $urandom_range(0, 6), 1'b0);
        end

        // 17 R-types from reset: the count wraps through zero to 1
        do_reset();
        start_cpu();
        repeat (17) do_instr(4'h0, 4'($urandom), 1'($urandom), 0, 1'b0);

        // SW timeout leads to BusError and HALT with the count unchanged
        do_instr(4'h5, 4'h0, 1'b0, -1, 1'b0);
        halt_cycles(3);

        // Every illegal opcode
        for (int k = 8; k <= 14; k++) begin
            do_reset();
            idle_cycles(1);
            start_cpu();
            do_instr(4'h1, 4'h0, 1'b0, 0, 1'b0);
            do_instr(4'(k), 4'($urandom), 1'b0, 0, 1'b0);
            halt_cycles(2);
        end

        // HALT opcode
        do_reset();
        idle_cycles(1);
        start_cpu();
        do_instr(4'h0, 4'h1, 1'b0, 0, 1'b0);
        do_instr(4'hF, 4'h0, 1'b0, 0, 1'b0);
        halt_cycles(3);

        // Reset during MEM aborts the access
        do_reset();
        start_cpu();
        do_instr(4'h4, 4'h0, 1'b0, 5, 1'b1);
        idle_cycles(2);
        start_cpu();
        do_instr(4'h5, 4'h0, 1'b0, 2, 1'b1);
        idle_cycles(2);

        @(negedge Clock);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
